// File: rtl/sgd_momentum_stream.sv
// Streaming SGD-with-momentum optimizer: one parameter/gradient pair per beat,
// per-element velocity kept internally, saturating fixed-point arithmetic.
module sgd_momentum_stream #(
  parameter int DATA_W     = 16,
  parameter int FRAC_BITS  = 8,
  parameter int NUM_PARAMS = 9,
  parameter int IDX_W      = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear_vel,
  input  logic [DATA_W-1:0] lr,
  input  logic [DATA_W-1:0] mu,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_param,
  input  logic [DATA_W-1:0] in_grad,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_param,
  output logic [IDX_W-1:0]  out_idx,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start
  // CLEAR | zeroing one velocity entry per cycle
  // RUN   | accepting parameter/gradient beats
  // FLUSH | waiting for the last output beat to be taken
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_FLUSH} state_t;

  localparam int SW = 2*DATA_W + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PARAMS - 1);
  localparam logic signed [SW-1:0] SMAX = SW'((2**(DATA_W-1)) - 1);
  localparam logic signed [SW-1:0] SMIN = -SMAX - SW'(1);

  state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic signed [DATA_W-1:0] lr_r, mu_r;
  logic signed [DATA_W-1:0] vel [NUM_PARAMS];
  logic signed [DATA_W-1:0] out_param_r;
  logic accept, out_take, done_nxt;

  logic signed [DATA_W-1:0]   v_rd, g_s, p_s, v_new, step, p_new;
  logic signed [2*DATA_W-1:0] prod_mv, prod_st;
  logic signed [SW-1:0]       sum_v, diff_p;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] x);
    if (x > SMAX)      sat = SMAX[DATA_W-1:0];
    else if (x < SMIN) sat = SMIN[DATA_W-1:0];
    else               sat = x[DATA_W-1:0];
  endfunction

  // datapath: full-width products, floor shift, then clamp at each stage
  assign v_rd    = vel[idx];
  assign g_s     = in_grad;
  assign p_s     = in_param;
  assign prod_mv = (2*DATA_W)'(mu_r) * (2*DATA_W)'(v_rd);
  assign sum_v   = SW'(prod_mv >>> FRAC_BITS) + SW'(g_s);
  assign v_new   = sat(sum_v);
  assign prod_st = (2*DATA_W)'(lr_r) * (2*DATA_W)'(v_new);
  assign step    = sat(SW'(prod_st >>> FRAC_BITS));
  assign diff_p  = SW'(p_s) - SW'(step);
  assign p_new   = sat(diff_p);

  assign accept    = in_valid & in_ready;
  assign out_take  = out_valid & out_ready;
  assign out_param = out_param_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = clear_vel ? S_CLEAR : S_RUN;
      S_CLEAR: if (idx == LAST) state_nxt = S_RUN;
      S_RUN:   if (accept && idx == LAST) state_nxt = S_FLUSH;
      S_FLUSH: if (out_take) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_RUN) && (!out_valid || out_ready);
    busy     = (state != S_IDLE);
    done_nxt = (state == S_FLUSH) && out_take;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      lr_r <= '0;
      mu_r <= '0;
      done <= 1'b0;
    end else begin
      done <= done_nxt;
      case (state)
        S_IDLE: begin
          idx <= '0;
          if (start) begin
            lr_r <= lr;
            mu_r <= mu;
          end
        end
        S_CLEAR: idx <= (idx == LAST) ? '0 : idx + 1'b1;
        S_RUN:   if (accept) idx <= (idx == LAST) ? '0 : idx + 1'b1;
        default: idx <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_PARAMS; k++) vel[k] <= '0;
    end else if (state == S_CLEAR) begin
      vel[idx] <= '0;
    end else if (accept) begin
      vel[idx] <= v_new;
    end
  end

  // single output register; a take and a reload may share one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_param_r <= '0;
      out_idx     <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_param_r <= p_new;
      out_idx     <= idx;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: doc/sgd_momentum_stream.md
Name: sgd_momentum_stream

Overview:
Sequential SGD-with-momentum optimizer that replaces the combinational all-parameters-at-once update. It streams one flattened parameter/gradient pair per beat over a valid/ready handshake. Per-parameter velocity is held in an internal register array, and results are produced with saturating fixed-point arithmetic. It sits between the backprop gradient stream and the parameter store; one pass over NUM_PARAMS elements is one training step.

Parameters:
DATA_W, 16, width of params, grads, lr, mu and velocity (signed two's complement)
FRAC_BITS, 8, fractional bits of every fixed-point quantity (Q(DATA_W-FRAC_BITS).FRAC_BITS)
NUM_PARAMS, 9, total weights plus biases per pass (flattened, weights first then biases)
IDX_W, $clog2(NUM_PARAMS), element index width (minimum 1)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a pass (ignored unless IDLE)
clear_vel  in  1  sampled with start; 1 = zero all velocities before the pass
lr  in  DATA_W  learning rate, latched on accepted start
mu  in  DATA_W  momentum coefficient, latched on accepted start
in_valid  in  1  input beat valid
in_ready  out  1  block can accept input beat
in_param  in  DATA_W  current parameter value
in_grad  in  DATA_W  gradient for that parameter
out_valid  out  1  updated parameter valid
out_ready  in  1  downstream accepts output
out_param  out  DATA_W  updated parameter
out_idx  out  IDX_W  element index of out_param
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after the last output beat is accepted

Behaviour:
- Reset (async, immediate): state=IDLE; in_ready=0, out_valid=0, out_param=0, out_idx=0, busy=0, done=0; lr/mu regs=0; index counter=0; all velocity entries=0. Reset mid-pass aborts the pass; no done is issued.
- FSM: IDLE -> (start & clear_vel) CLEAR | (start & !clear_vel) RUN.
- CLEAR: zeroes one velocity entry per cycle over NUM_PARAMS cycles, then enters RUN. in_ready=0.
- RUN: in_ready = !out_valid | out_ready (single output register, no skid). An accept (in_valid & in_ready) processes element idx and increments idx. The accept of element NUM_PARAMS-1 moves to FLUSH.
- FLUSH: in_ready=0. When the last output beat is accepted, pulse done for 1 cycle and return to IDLE. idx resets to 0.
- A start pulse while busy is ignored. lr/mu are stable for the whole pass.
- Per accepted element i (all values signed):
  - mv = (mu * v[i]) >>> FRAC_BITS, with the full 2*DATA_W product arithmetically shifted (floor).
  - v_new = sat(mv + g).
  - step = sat((lr * v_new) >>> FRAC_BITS).
  - p_new = sat(p - step).
  - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Intermediate sums are at least DATA_W+1 bits wide.
  - v[i] <= v_new on the accept edge. out_param <= p_new and out_idx <= i on the same edge.
- Latency: 1 cycle from input accept to out_valid. Throughput: 1 element/cycle when out_ready stays high.
- out_valid holds with stable out_param/out_idx until out_ready. A simultaneous output accept and new input accept in the same cycle is legal and reloads the register.
- With mu=0 the block reduces to plain SGD: p - ((lr*g)>>>FRAC_BITS), saturated.
- Velocity persists across passes until clear_vel or reset.
- Single-ported velocity array: combinational read at idx, write on accept. No read-after-write hazard, since each index is touched once per pass.

Test Plan:
- Plain SGD (NUM_PARAMS=9, FRAC_BITS=8): clear_vel=1, mu=0, lr=256, all p=512, g=256 -> 9 outputs of 256, out_idx 0..8, done 1 cycle after last accept.
- Momentum across passes: mu=128, lr=256, p=512, g=256. Pass1 (clear) -> out 256. Feed p=256, g=256 in pass2 without clear -> v=384, out -128.
- Saturation: mu=0, lr=256, p=-32000, g=32767 -> out -32768. Also p=32000, g=-32767 -> out 32767.
- Backpressure: out_ready low for 5 cycles mid-pass -> in_ready=0 while out_valid held. out_param stays stable with no drops or duplicates, and the indices are in order.
- CLEAR timing: start with clear_vel=1 -> in_ready stays 0 for exactly NUM_PARAMS cycles. Prior velocity is ignored (output matches the mu=0 result).
- Reset mid-RUN after 4 elements: all outputs 0, no done. A new pass with mu=128 and no clear behaves as zero velocity.
